hdmi_tmds_encoder: RTL and testbench



---
 rtl/hdmi_pkg.sv | 32 +++
 rtl/tmds_channel_enc.sv | 114 +++++++++++
 rtl/hdmi_tmds_encoder.sv | 34 +++
 tb/tb_hdmi_tmds_encoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared TMDS constants, the balance-case enum and a popcount helper.
package hdmi_pkg;

    localparam int TMDS_CHAR_W = 10;

    // Control-period characters, bit9..bit0, indexed by C = {C1, C0}.
    localparam logic [TMDS_CHAR_W-1:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [TMDS_CHAR_W-1:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [TMDS_CHAR_W-1:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [TMDS_CHAR_W-1:0] TMDS_CTRL_11 = 10'h2AB;

    // Character shown on every lane while reset is held.
    localparam logic [TMDS_CHAR_W-1:0] TMDS_RESET_CHAR = TMDS_CTRL_00;

    // Which DC-balance rule applies to the current data character.
    typedef enum logic [1:0] {
        BAL_NEUTRAL = 2'd0,  // cnt==0 or q_m byte balanced
        BAL_INVERT  = 2'd1,  // byte would push disparity further out: invert
        BAL_KEEP    = 2'd2   // byte pulls disparity back: send as is
    } bal_case_e;

    // Number of ones in a byte.
    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 8; k++) begin
            n = n + {3'd0, d[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS lane: stage 1 builds the transition-minimised q_m word,
// stage 2 applies DC balancing against the lane's running disparity.
module tmds_channel_enc
    import hdmi_pkg::*;
(
    input  logic                   clk_pixel,
    input  logic                   rst_n,
    input  logic                   i_de,
    input  logic [1:0]             i_ctrl,
    input  logic [7:0]             i_data,
    output logic [TMDS_CHAR_W-1:0] o_char
);

    logic [3:0]             w_n1_d;
    logic                   w_use_xnor;
    logic [8:0]             w_qm;

    logic [8:0]             r_qm;
    logic                   r_de;
    logic [1:0]             r_ctrl;

    logic [3:0]             w_n1_q;
    logic signed [5:0]      w_bal;      // N1 - N0 of q_m[7:0]
    logic signed [5:0]      w_cnt_ext;
    logic signed [5:0]      w_sum;
    bal_case_e              w_case;
    logic [TMDS_CHAR_W-1:0] w_char_next;
    logic signed [4:0]      w_cnt_next;

    logic [TMDS_CHAR_W-1:0] r_char;
    logic signed [4:0]      r_cnt;

    // Stage 1 combinational: choose XOR or XNOR chaining from the byte's ones count.
    always_comb begin
        w_n1_d     = popcount8(i_data);
        w_use_xnor = (w_n1_d > 4'd4) || ((w_n1_d == 4'd4) && !i_data[0]);
        w_qm       = '0;
        w_qm[0]    = i_data[0];
        for (int k = 1; k < 8; k++) begin
            w_qm[k] = w_use_xnor ? ~(w_qm[k-1] ^ i_data[k]) : (w_qm[k-1] ^ i_data[k]);
        end
        w_qm[8]    = ~w_use_xnor;
    end

    // Stage 1 register: q_m plus the control fields travelling alongside it.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_qm   <= '0;
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
        end else begin
            r_qm   <= w_qm;
            r_de   <= i_de;
            r_ctrl <= i_ctrl;
        end
    end

    // Stage 2 combinational: pick the balance rule, form the character and next disparity.
    always_comb begin
        w_n1_q      = popcount8(r_qm[7:0]);
        w_bal       = $signed({1'b0, w_n1_q, 1'b0}) - 6'sd8;
        w_cnt_ext   = {r_cnt[4], r_cnt};
        w_case      = BAL_KEEP;
        w_sum       = w_cnt_ext;
        w_char_next = TMDS_CTRL_00;

        if ((r_cnt == 5'sd0) || (w_bal == 6'sd0)) begin
            w_case = BAL_NEUTRAL;
        end else if ((!r_cnt[4] && (w_bal > 6'sd0)) || (r_cnt[4] && (w_bal < 6'sd0))) begin
            w_case = BAL_INVERT;
        end

        case (w_case)
            BAL_NEUTRAL: begin
                w_char_next = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                w_sum       = r_qm[8] ? (w_cnt_ext + w_bal) : (w_cnt_ext - w_bal);
            end
            BAL_INVERT: begin
                w_char_next = {1'b1, r_qm[8], ~r_qm[7:0]};
                w_sum       = w_cnt_ext + (r_qm[8] ? 6'sd2 : 6'sd0) - w_bal;
            end
            default: begin
                w_char_next = {1'b0, r_qm[8], r_qm[7:0]};
                w_sum       = w_cnt_ext - (r_qm[8] ? 6'sd0 : 6'sd2) + w_bal;
            end
        endcase
        w_cnt_next = w_sum[4:0];

        // Blanking overrides the data path and re-centres the disparity.
        if (!r_de) begin
            w_cnt_next = 5'sd0;
            case (r_ctrl)
                2'b01:   w_char_next = TMDS_CTRL_01;
                2'b10:   w_char_next = TMDS_CTRL_10;
                2'b11:   w_char_next = TMDS_CTRL_11;
                default: w_char_next = TMDS_CTRL_00;
            endcase
        end
    end

    // Stage 2 register: output character and running disparity.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_char <= TMDS_RESET_CHAR;
            r_cnt  <= 5'sd0;
        end else begin
            r_char <= w_char_next;
            r_cnt  <= w_cnt_next;
        end
    end

    assign o_char = r_char;

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// Three-lane TMDS encoder: one tmds_channel_enc per colour, sync codes on lane 0.
module hdmi_tmds_encoder
    import hdmi_pkg::*;
#(
    parameter int N_CHANNELS = 3   // only 3 lanes are meaningful for HDMI/DVI
)(
    input  logic                              clk_pixel,
    input  logic                              rst_n,
    input  logic                              de,
    input  logic                              hsync,
    input  logic                              vsync,
    input  logic [8*N_CHANNELS-1:0]           pixel,
    output logic [TMDS_CHAR_W*N_CHANNELS-1:0] tmds_internal
);

    generate
        for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_lane
            logic [1:0] w_ctrl;

            // Lane 0 carries {vsync, hsync} during blanking; other lanes send C=00.
            assign w_ctrl = (gi == 0) ? {vsync, hsync} : 2'b00;

            tmds_channel_enc u_enc (
                .clk_pixel (clk_pixel),
                .rst_n     (rst_n),
                .i_de      (de),
                .i_ctrl    (w_ctrl),
                .i_data    (pixel[8*gi +: 8]),
                .o_char    (tmds_internal[TMDS_CHAR_W*gi +: TMDS_CHAR_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Scoreboard bench for hdmi_tmds_encoder: stimulus pushes expected characters,
// a negedge monitor pops and compares, and decodes data characters back to pixels.
module tb_hdmi_tmds_encoder;

    logic        clk_pixel = 1'b0;
    logic        rst_n     = 1'b0;
    logic        de        = 1'b0;
    logic        hsync     = 1'b0;
    logic        vsync     = 1'b0;
    logic [23:0] pixel     = 24'h0;
    logic [29:0] tmds_internal;

    hdmi_tmds_encoder #(.N_CHANNELS(3)) dut (
        .clk_pixel     (clk_pixel),
        .rst_n         (rst_n),
        .de            (de),
        .hsync         (hsync),
        .vsync         (vsync),
        .pixel         (pixel),
        .tmds_internal (tmds_internal)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct packed {
        logic [29:0] exp;
        logic        is_data;
        logic [23:0] pix;
    } sb_item_t;

    sb_item_t sb[$];
    int       n_tests = 0;
    int       n_fail  = 0;
    logic     mon_en  = 1'b0;
    int       m_cnt[3];

    localparam logic [9:0] BLANK = 10'h354;

    // Control character from the published code table.
    function automatic logic [9:0] ref_ctrl(input logic [1:0] c);
        case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    // Reference encoder for one data byte on one lane, tracking disparity as an int.
    function automatic logic [9:0] ref_encode(input int lane, input logic [7:0] d);
        logic [7:0] qm;
        logic       q8;
        logic [9:0] ch;
        int         n1d, n1, n0, c;
        n1d = $countones(d);
        q8  = !((n1d > 4) || (n1d == 4 && d[0] == 1'b0));
        qm[0] = d[0];
        for (int k = 1; k < 8; k++) qm[k] = q8 ? (qm[k-1] ^ d[k]) : !(qm[k-1] ^ d[k]);
        n1 = $countones(qm);
        n0 = 8 - n1;
        c  = m_cnt[lane];
        if (c == 0 || n1 == n0) begin
            ch = {!q8, q8, q8 ? qm : ~qm};
            c  = c + (q8 ? (n1 - n0) : (n0 - n1));
        end else if ((c > 0 && n1 > n0) || (c < 0 && n0 > n1)) begin
            ch = {1'b1, q8, ~qm};
            c  = c + (q8 ? 2 : 0) + (n0 - n1);
        end else begin
            ch = {1'b0, q8, qm};
            c  = c - (q8 ? 0 : 2) + (n1 - n0);
        end
        m_cnt[lane] = c;
        n_tests++;
        if (c > 10 || c < -10) begin
            n_fail++;
            $display("FAIL cnt_range lane=%0d cnt=%0d required=-10..10", lane, c);
        end
        return ch;
    endfunction

    // Inverse of the TMDS data mapping, used on what the DUT actually sent.
    function automatic logic [7:0] ref_decode(input logic [9:0] ch);
        logic [7:0] q;
        logic [7:0] d;
        q    = ch[9] ? ~ch[7:0] : ch[7:0];
        d[0] = q[0];
        for (int k = 1; k < 8; k++) d[k] = ch[8] ? (q[k] ^ q[k-1]) : !(q[k] ^ q[k-1]);
        return d;
    endfunction

    // Drive one cycle of input and queue the characters it must produce.
    task automatic drive_cycle(input logic d_i, input logic h_i, input logic v_i,
                               input logic [23:0] p_i);
        sb_item_t it;
        @(posedge clk_pixel);
        #1;
        de = d_i; hsync = h_i; vsync = v_i; pixel = p_i;
        it.is_data = d_i;
        it.pix     = p_i;
        if (d_i) begin
            for (int l = 0; l < 3; l++) it.exp[10*l +: 10] = ref_encode(l, p_i[8*l +: 8]);
        end else begin
            it.exp = {BLANK, BLANK, ref_ctrl({v_i, h_i})};
            for (int l = 0; l < 3; l++) m_cnt[l] = 0;
        end
        sb.push_back(it);
    endtask

    // Assert reset between edges, check the immediate blanking output, release.
    task automatic apply_reset();
        sb_item_t it;
        mon_en = 1'b0;
        sb.delete();
        @(posedge clk_pixel);
        #3;
        rst_n = 1'b0;
        de = 1'b0; hsync = 1'b0; vsync = 1'b0; pixel = 24'h0;
        #1;
        n_tests++;
        if (tmds_internal !== {BLANK, BLANK, BLANK}) begin
            n_fail++;
            $display("FAIL reset_async got=%h required=%h", tmds_internal, {BLANK, BLANK, BLANK});
        end
        rst_n = 1'b1;
        for (int l = 0; l < 3; l++) m_cnt[l] = 0;
        // Held output, reset stage-1 contents, and the idle input at the first edge.
        it.exp = {BLANK, BLANK, BLANK};
        it.is_data = 1'b0;
        it.pix = 24'h0;
        for (int i = 0; i < 3; i++) sb.push_back(it);
        mon_en = 1'b1;
    endtask

    // Monitor: one pop and compare per output cycle.
    always @(negedge clk_pixel) begin
        sb_item_t it;
        logic [23:0] dec;
        if (mon_en && sb.size() > 0) begin
            it = sb.pop_front();
            n_tests++;
            if (tmds_internal !== it.exp) begin
                n_fail++;
                $display("FAIL tmds_char got=%h required=%h", tmds_internal, it.exp);
            end else begin
                $display("[TB] char ok %h data=%0d", tmds_internal, it.is_data);
            end
            if (it.is_data) begin
                for (int l = 0; l < 3; l++) dec[8*l +: 8] = ref_decode(tmds_internal[10*l +: 10]);
                n_tests++;
                if (dec !== it.pix) begin
                    n_fail++;
                    $display("FAIL pixel_decode got=%h required=%h", dec, it.pix);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout with %0d items pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        apply_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 24'h0);

        // Sync codes on lane 0.
        drive_cycle(1'b0, 1'b1, 1'b0, 24'h0);
        drive_cycle(1'b0, 1'b1, 1'b1, 24'h0);
        drive_cycle(1'b0, 1'b0, 1'b1, 24'h0);
        drive_cycle(1'b0, 1'b0, 1'b0, 24'h0);

        // Zero pixels after blanking: 0x100, 0x3FF, 0x100 per lane.
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 24'h000000);
        drive_cycle(1'b0, 1'b0, 1'b0, 24'h0);

        // Tie case on blue as a single-cycle data pulse.
        drive_cycle(1'b1, 1'b0, 1'b0, 24'h00000F);
        drive_cycle(1'b0, 1'b0, 1'b0, 24'h0);
        drive_cycle(1'b0, 1'b0, 1'b0, 24'h0);

        // Mid-line reset, then the zero sequence must restart.
        drive_cycle(1'b1, 1'b0, 1'b0, 24'h000000);
        drive_cycle(1'b1, 1'b0, 1'b0, 24'h000000);
        drive_cycle(1'b1, 1'b0, 1'b0, 24'h000000);
        apply_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 24'h000000);
        drive_cycle(1'b0, 1'b0, 1'b0, 24'h0);

        // Soak: random pixels with random blanking gaps and sync levels.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                gap = $urandom_range(1, 4);
                for (int g = 0; g < gap; g++)
                    drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'h0);
            end
            drive_cycle(1'b1, 1'b0, 1'b0, 24'($urandom));
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 24'h0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_pixel);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
        end
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
